// File: rtl/padbi_seq.sv
// padbi_seq: arbitrates level write/read requests onto one bidirectional pad group, inserting EN-low bus turnaround.
// Latency: WR_ACK TURN_CYC+1 cycles after the grant edge (1 when turnaround is skipped); RD_ACK TURN_CYC+RD_WAIT+1.
// Backpressure: requests are held until ACK and sampled only in IDLE; one transfer in flight, round-robin on ties.
// Build option: define PADBI_SEQ_SAMEDIR_SKIP_EN to skip TURN when the pad already faces the granted direction.
module padbi_seq #(
    parameter int M        = 7,
    parameter int N        = 0,
    parameter int TURN_CYC = 1,   // 1..15
    parameter int RD_WAIT  = 1    // 1..15
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         WR_REQ,
    input  logic [M:N]   WR_DATA,
    output logic         WR_ACK,
    input  logic         RD_REQ,
    output logic [M:N]   RD_DATA,
    output logic         RD_ACK,
    output logic         EN,
    output logic         DIR,
    output logic [M:N]   BIO_OUT,
    input  logic [M:N]   BIO_IN,
    output logic         BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    localparam logic [3:0] TURN_LD = 4'(TURN_CYC);
    localparam logic [3:0] RD_LD   = 4'(RD_WAIT);

    state_t     state, nxt_state;
    logic [3:0] cnt, nxt_cnt;
    logic       last_rd, nxt_last_rd;   // last granted transfer was a read
    logic       tgt_wr, nxt_tgt_wr;     // granted transfer is a write
    logic [M:N] wdat, nxt_wdat;
    logic       nxt_en, nxt_dir, nxt_wr_ack, nxt_rd_ack, nxt_busy;
    logic [M:N] nxt_bio_out, nxt_rd_data;
    logic       rd_req_eff, grant_wr, grant_rd, need_turn;

    // The read requester still holds RD_REQ during its own RD_ACK cycle (which is an
    // IDLE cycle), so a read request is ignored while RD_ACK is up to avoid a repeat read.
    assign rd_req_eff = RD_REQ & ~RD_ACK;
    assign grant_wr   = WR_REQ & (~rd_req_eff | last_rd);
    assign grant_rd   = rd_req_eff & (~WR_REQ | ~last_rd);

`ifdef PADBI_SEQ_SAMEDIR_SKIP_EN
    assign need_turn = (grant_wr != DIR);
`else
    assign need_turn = 1'b1;
`endif

    // State, counter and registered outputs; reset aborts any transfer without an ack.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            last_rd <= 1'b1;
            tgt_wr  <= 1'b0;
            wdat    <= '0;
            EN      <= 1'b0;
            DIR     <= 1'b0;
            BIO_OUT <= '0;
            RD_DATA <= '0;
            WR_ACK  <= 1'b0;
            RD_ACK  <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            last_rd <= nxt_last_rd;
            tgt_wr  <= nxt_tgt_wr;
            wdat    <= nxt_wdat;
            EN      <= nxt_en;
            DIR     <= nxt_dir;
            BIO_OUT <= nxt_bio_out;
            RD_DATA <= nxt_rd_data;
            WR_ACK  <= nxt_wr_ack;
            RD_ACK  <= nxt_rd_ack;
            BUSY    <= nxt_busy;
        end
    end

    // Next state plus next values of every output, so all outputs come straight from flops.
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_last_rd = last_rd;
        nxt_tgt_wr  = tgt_wr;
        nxt_wdat    = wdat;
        nxt_en      = 1'b0;
        nxt_dir     = DIR;
        nxt_bio_out = BIO_OUT;
        nxt_rd_data = RD_DATA;
        nxt_wr_ack  = 1'b0;
        nxt_rd_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_wr || grant_rd) begin
                    nxt_tgt_wr  = grant_wr;
                    nxt_last_rd = grant_rd;
                    if (grant_wr) begin
                        nxt_wdat = WR_DATA;
                    end
                    if (need_turn) begin
                        nxt_state = TURN;
                        nxt_cnt   = TURN_LD;
                        nxt_dir   = grant_wr;
                    end else if (grant_wr) begin
                        nxt_state   = WRITE;
                        nxt_en      = 1'b1;
                        nxt_dir     = 1'b1;
                        nxt_bio_out = WR_DATA;
                        nxt_wr_ack  = 1'b1;
                    end else begin
                        nxt_state = READ;
                        nxt_cnt   = RD_LD;
                        nxt_en    = 1'b1;
                        nxt_dir   = 1'b0;
                    end
                end
            end
            TURN: begin
                if (cnt == 4'd1) begin
                    nxt_en = 1'b1;
                    if (tgt_wr) begin
                        nxt_state   = WRITE;
                        nxt_cnt     = 4'd0;
                        nxt_dir     = 1'b1;
                        nxt_bio_out = wdat;
                        nxt_wr_ack  = 1'b1;
                    end else begin
                        nxt_state = READ;
                        nxt_cnt   = RD_LD;
                        nxt_dir   = 1'b0;
                    end
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            WRITE: begin
                nxt_state = IDLE;
            end
            READ: begin
                if (cnt == 4'd1) begin
                    nxt_state   = IDLE;
                    nxt_cnt     = 4'd0;
                    nxt_rd_data = BIO_IN;
                    nxt_rd_ack  = 1'b1;
                end else begin
                    nxt_cnt = cnt - 4'd1;
                    nxt_en  = 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = 4'd0;
            end
        endcase
        nxt_busy = (nxt_state != IDLE);
    end

endmodule
